// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor D = a - b with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
  output logic             Bout,
  output logic             ovf
`else
  output logic             Bout
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  // Holds the WIDTH-1 already-computed bits; the final bit completes it.
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             sign_a;
  logic             sign_b;
`endif

  logic             d_bit;
  logic             bw_next;
  logic [WIDTH-1:0] full;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d_bit   = sh_a[0] ^ sh_b[0] ^ borrow;
    bw_next = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & borrow);
    full    = {d_bit, res};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, which keeps the cell, shift and counter updates coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a   <= a;
            sh_b   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          res    <= full[WIDTH-1:1];
          borrow <= bw_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            D     <= full;
            Bout  <= bw_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (sign_a ^ sign_b) & (sign_a ^ d_bit);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Define SERIAL_SUB_OVF_EN to also exercise the signed-overflow output.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] D;
  logic       Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .D     (D),
`ifdef SERIAL_SUB_OVF_EN
    .Bout  (Bout),
    .ovf   (ovf)
`else
    .Bout  (Bout)
`endif
  );

  always #5 clk = ~clk;

  // Issue one request, then wait (bounded) for done; returns at the done cycle.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output int busy_cycles, output bit seen);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, D, Bout} !== 11'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b D=%h Bout=%b, want all zero", busy, done, D, Bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b want 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int  bc;
    bit  seen;
    run_op(8'd100, 8'd37, bc, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL basic_done: no done pulse within budget");
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL basic_busy: busy cycles=%0d want 8", bc);
    end
    checks++;
    if (D !== 8'd63 || Bout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: D=%0d Bout=%b want 63/0", D, Bout);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [3] = '{8'd37, 8'd0,   8'hA5};
    logic [7:0] vb [3] = '{8'd100, 8'd255, 8'hA5};
    logic [7:0] vd [3] = '{8'hC1, 8'h01,  8'h00};
    logic       vw [3] = '{1'b1,  1'b1,   1'b0};
    int  bc;
    bit  seen;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], bc, seen);
      checks++;
      if (!seen || D !== vd[i] || Bout !== vw[i]) begin
        errors++;
        $display("FAIL vector%0d: seen=%b D=%h Bout=%b want D=%h Bout=%b",
                 i, seen, D, Bout, vd[i], vw[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int         pulses = 0;
    logic [7:0] got = '0;
    @(negedge clk);
    a = 8'd10; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd200; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'd0; b = 8'd0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin pulses++; got = D; end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL busy_start_pulses: done pulses=%0d want 1", pulses);
    end
    checks++;
    if (got !== 8'd7) begin
      errors++;
      $display("FAIL busy_start_result: D=%0d want 7", got);
    end
  endtask

  task automatic test_reset_mid_shift();
    int  pulses = 0;
    int  bc;
    bit  seen;
    @(negedge clk);
    a = 8'd50; b = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || D !== 8'd0 || Bout !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b D=%h Bout=%b want all zero", busy, done, D, Bout);
    end
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d want 0", pulses);
    end
    run_op(8'd50, 8'd20, bc, seen);
    checks++;
    if (!seen || D !== 8'd30 || Bout !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover: seen=%b D=%0d Bout=%b want 30/0", seen, D, Bout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [4] = '{8'd100, 8'd1,   8'd255, 8'd128};
    logic [7:0] pb [4] = '{8'd37,  8'd2,   8'd255, 8'd127};
    logic [7:0] pd [4] = '{8'd63,  8'd255, 8'd0,   8'd1};
    logic       pw [4] = '{1'b0,   1'b1,   1'b0,   1'b0};
    logic [7:0] prev_d = 8'd30;
    logic       prev_w = 1'b0;
    int k = 0;
    int last = 0;
    @(negedge clk);
    a = pa[0]; b = pb[0]; start = 1'b1;
    for (int cyc = 1; cyc <= 60 && k < 4; cyc++) begin
      @(negedge clk);
      if (done) begin
        checks++;
        if (D !== pd[k] || Bout !== pw[k]) begin
          errors++;
          $display("FAIL b2b_result%0d: D=%0d Bout=%b want %0d/%b", k, D, Bout, pd[k], pw[k]);
        end
        if (k > 0) begin
          checks++;
          if (cyc - last !== 10) begin
            errors++;
            $display("FAIL b2b_spacing%0d: %0d cycles want 10", k, cyc - last);
          end
        end
        last = cyc; prev_d = pd[k]; prev_w = pw[k];
        k++;
        if (k < 4) begin a = pa[k]; b = pb[k]; end
        else start = 1'b0;
      end else begin
        checks++;
        if (D !== prev_d || Bout !== prev_w) begin
          errors++;
          $display("FAIL b2b_hold: D=%0d Bout=%b want %0d/%b", D, Bout, prev_d, prev_w);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL b2b_count: %0d completions want 4", k);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [7:0] va [3] = '{8'h80, 8'h7F, 8'h05};
    logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h03};
    logic [7:0] vd [3] = '{8'h7F, 8'h80, 8'h02};
    logic       vo [3] = '{1'b1,  1'b1,  1'b0};
    int  bc;
    bit  seen;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], bc, seen);
      checks++;
      if (!seen || D !== vd[i] || ovf !== vo[i]) begin
        errors++;
        $display("FAIL ovf%0d: seen=%b D=%h ovf=%b want D=%h ovf=%b",
                 i, seen, D, ovf, vd[i], vo[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_start_while_busy();
    test_reset_mid_shift();
    test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
